// File: rtl/regfile_mp.sv
// regfile_mp
//   Multi-port integer register file for the decode stage, with a pending
//   (busy) bit per register that issue logic sets and writeback clears.
//
// Ports
//   clk, rst            clock; synchronous active-high reset (clears data and busy)
//   rd_addr  [NUM_RD*ADDR_WIDTH]  packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data  [NUM_RD*DATA_WIDTH]  packed combinational read data
//   rd_busy  [NUM_RD]             combinational per-port pending flag
//   wr0_*                write port 0 (low priority)
//   wr1_*                write port 1 (high priority)
//   iss_en, iss_addr     mark a destination register as pending
//   a0                   stored contents of register 10, never bypassed
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 3,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic                           wr0_en,
  input  logic [ADDR_WIDTH-1:0]          wr0_addr,
  input  logic [DATA_WIDTH-1:0]          wr0_data,
  input  logic                           wr1_en,
  input  logic [ADDR_WIDTH-1:0]          wr1_addr,
  input  logic [DATA_WIDTH-1:0]          wr1_data,
  input  logic                           iss_en,
  input  logic [ADDR_WIDTH-1:0]          iss_addr,
  output logic [DATA_WIDTH-1:0]          a0
);

  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0]      busy;

  logic wr0_live;
  logic wr1_live;
  logic iss_live;

  // x0 is hardwired: any strobe aimed at it is dropped here.
  assign wr0_live = wr0_en && (wr0_addr != '0);
  assign wr1_live = wr1_en && (wr1_addr != '0);
  assign iss_live = iss_en && (iss_addr != '0);

  // State update. Port 1 is written after port 0 so it wins a collision;
  // the issue set is last so a same-cycle issue keeps the register busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr0_live) begin
        regs[wr0_addr] <= wr0_data;
        busy[wr0_addr] <= 1'b0;
      end
      if (wr1_live) begin
        regs[wr1_addr] <= wr1_data;
        busy[wr1_addr] <= 1'b0;
      end
      if (iss_live) begin
        busy[iss_addr] <= 1'b1;
      end
    end
  end

  // Read ports.
  logic [ADDR_WIDTH-1:0] ra;
  logic [DATA_WIDTH-1:0] rdat;
  logic                  rb;
  logic                  hit0;
  logic                  hit1;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rdat    = '0;
    rb      = 1'b0;
    hit0    = 1'b0;
    hit1    = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra   = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      hit0 = wr0_live && (wr0_addr == ra);
      hit1 = wr1_live && (wr1_addr == ra);
      rdat = regs[ra];
      rb   = busy[ra];
      if (BYPASS != 0) begin
        if (hit1) begin
          rdat = wr1_data;
        end else if (hit0) begin
          rdat = wr0_data;
        end
        // A writeback landing this cycle resolves the pending producer now.
        if (hit0 || hit1) begin
          rb = 1'b0;
        end
      end
      // Guard x0 explicitly so it reads 0 even before the first reset.
      if (ra == '0) begin
        rdat = '0;
        rb   = 1'b0;
      end
      rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rdat;
      rd_busy[i]                          = rb;
    end
  end

  assign a0 = regs[A0_IDX];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
//   Drives a BYPASS=1 and a BYPASS=0 copy of regfile_mp with the same
//   directed vectors. Stimulus pushes hand-computed expectations tagged with
//   the cycle they apply to; a monitor pops and compares on the falling edge.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_busy_b, rd_busy_n;
  logic             wr0_en, wr1_en, iss_en;
  logic [AW-1:0]    wr0_addr, wr1_addr, iss_addr;
  logic [DW-1:0]    wr0_data, wr1_data;
  logic [DW-1:0]    a0_b, a0_n;

  regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .a0(a0_b)
  );

  regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .a0(a0_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          cyc;
    bit          byp;
    int          port;
    logic [31:0] data;
    logic        busy;
    bit          is_a0;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    n_pass  = 0;
  int    n_total = 0;

  // Monitor: compares every expectation due in the current cycle.
  exp_t        me;
  string       mn;
  logic [31:0] got_d;
  logic        got_b;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      me = q.pop_front();
      mn = qn.pop_front();
      n_total++;
      if (me.is_a0) begin
        got_d = me.byp ? a0_b : a0_n;
        if (got_d === me.data) n_pass++;
        else $display("FAIL %s (bypass=%0d): a0 got %h, want %h", mn, me.byp, got_d, me.data);
      end else begin
        got_d = me.byp ? rd_data_b[me.port*DW +: DW] : rd_data_n[me.port*DW +: DW];
        got_b = me.byp ? rd_busy_b[me.port] : rd_busy_n[me.port];
        if (got_d === me.data && got_b === me.busy) n_pass++;
        else $display("FAIL %s (bypass=%0d port %0d): got data=%h busy=%b, want data=%h busy=%b",
                      mn, me.byp, me.port, got_d, got_b, me.data, me.busy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
  endtask

  task automatic set_rd(input int a, input int b, input int c);
    rd_addr = {AW'(c), AW'(b), AW'(a)};
  endtask

  task automatic exp_rd(input bit byp, input int port, input logic [31:0] d,
                        input logic b, input string nm);
    q.push_back('{cyc: cyc, byp: byp, port: port, data: d, busy: b, is_a0: 1'b0});
    qn.push_back(nm);
  endtask

  task automatic exp_both(input int port, input logic [31:0] d, input logic b, input string nm);
    exp_rd(1'b1, port, d, b, nm);
    exp_rd(1'b0, port, d, b, nm);
  endtask

  task automatic exp_a0(input logic [31:0] d, input string nm);
    q.push_back('{cyc: cyc, byp: 1'b1, port: 0, data: d, busy: 1'b0, is_a0: 1'b1});
    qn.push_back(nm);
    q.push_back('{cyc: cyc, byp: 1'b0, port: 0, data: d, busy: 1'b0, is_a0: 1'b1});
    qn.push_back(nm);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wr0_addr = '0; wr1_addr = '0; iss_addr = '0;
    wr0_data = '0; wr1_data = '0;
    set_rd(0, 0, 0);
    step(); step();
    rst = 1'b0;

    // Reset state
    set_rd(0, 5, 31);
    exp_both(0, 32'h0, 1'b0, "reset_x0");
    exp_both(1, 32'h0, 1'b0, "reset_x5");
    exp_both(2, 32'h0, 1'b0, "reset_x31");
    exp_a0(32'h0, "reset_a0");

    // x0: write and issue are both discarded, no bypass either
    step();
    wr1_en = 1'b1; wr1_addr = 0; wr1_data = 32'hDEADBEEF;
    iss_en = 1'b1; iss_addr = 0;
    set_rd(0, 0, 0);
    exp_rd(1'b1, 0, 32'h0, 1'b0, "x0_same_cycle");
    step();
    idle();
    exp_both(0, 32'h0, 1'b0, "x0_after");

    // Write collision on x10: port 1 wins
    step();
    wr0_en = 1'b1; wr0_addr = 10; wr0_data = 32'h11111111;
    wr1_en = 1'b1; wr1_addr = 10; wr1_data = 32'h22222222;
    set_rd(10, 0, 0);
    exp_rd(1'b1, 0, 32'h22222222, 1'b0, "collide_bypass");
    exp_rd(1'b0, 0, 32'h0, 1'b0, "collide_nobypass");
    exp_a0(32'h0, "collide_a0_same");
    step();
    idle();
    exp_a0(32'h22222222, "collide_a0_next");
    exp_both(0, 32'h22222222, 1'b0, "collide_x10_next");

    // Independent write ports, separate read ports
    step();
    wr0_en = 1'b1; wr0_addr = 3; wr0_data = 32'd7;
    wr1_en = 1'b1; wr1_addr = 4; wr1_data = 32'd9;
    set_rd(3, 4, 0);
    exp_rd(1'b1, 0, 32'd7, 1'b0, "indep_x3_bypass");
    exp_rd(1'b1, 1, 32'd9, 1'b0, "indep_x4_bypass");
    exp_rd(1'b0, 0, 32'd0, 1'b0, "indep_x3_nobypass");
    exp_rd(1'b0, 1, 32'd0, 1'b0, "indep_x4_nobypass");
    step();
    idle();
    exp_both(0, 32'd7, 1'b0, "indep_x3_next");
    exp_both(1, 32'd9, 1'b0, "indep_x4_next");

    // Scoreboard: issue x5, then clear with a write
    step();
    iss_en = 1'b1; iss_addr = 5;
    set_rd(5, 0, 0);
    exp_both(0, 32'h0, 1'b0, "issue_x5_same");
    step();
    idle();
    wr1_en = 1'b1; wr1_addr = 5; wr1_data = 32'h55;
    exp_rd(1'b1, 0, 32'h55, 1'b0, "clear_x5_bypass");
    exp_rd(1'b0, 0, 32'h0, 1'b1, "clear_x5_nobypass");
    step();
    idle();
    exp_both(0, 32'h55, 1'b0, "clear_x5_next");

    // Issue and write x6 together: data commits, busy stays set
    step();
    iss_en = 1'b1; iss_addr = 6;
    wr0_en = 1'b1; wr0_addr = 6; wr0_data = 32'h66;
    set_rd(6, 0, 0);
    exp_rd(1'b1, 0, 32'h66, 1'b0, "iss_wr_x6_bypass");
    exp_rd(1'b0, 0, 32'h0, 1'b0, "iss_wr_x6_nobypass");
    step();
    idle();
    exp_both(0, 32'h66, 1'b1, "iss_wr_x6_busy");

    // Second write clears x6; two ports read the same register
    step();
    wr1_en = 1'b1; wr1_addr = 6; wr1_data = 32'h67;
    set_rd(6, 6, 0);
    exp_rd(1'b1, 0, 32'h67, 1'b0, "x6_clear_p0_bypass");
    exp_rd(1'b1, 1, 32'h67, 1'b0, "x6_clear_p1_bypass");
    exp_rd(1'b0, 0, 32'h66, 1'b1, "x6_clear_p0_nobypass");
    exp_rd(1'b0, 1, 32'h66, 1'b1, "x6_clear_p1_nobypass");
    step();
    idle();
    exp_both(0, 32'h67, 1'b0, "x6_clear_next");

    // Reset overrides write and issue; all state clears
    step();
    rst = 1'b1;
    wr0_en = 1'b1; wr0_addr = 7; wr0_data = 32'hAB;
    iss_en = 1'b1; iss_addr = 7;
    set_rd(7, 10, 5);
    step();
    rst = 1'b0;
    idle();
    exp_both(0, 32'h0, 1'b0, "rst_x7");
    exp_both(1, 32'h0, 1'b0, "rst_x10");
    exp_both(2, 32'h0, 1'b0, "rst_x5");
    exp_a0(32'h0, "rst_a0");

    // Top address through the low-priority port
    step();
    wr0_en = 1'b1; wr0_addr = 31; wr0_data = 32'hFFFFFFFF;
    set_rd(0, 0, 31);
    exp_rd(1'b1, 2, 32'hFFFFFFFF, 1'b0, "x31_bypass");
    exp_rd(1'b0, 2, 32'h0, 1'b0, "x31_nobypass");
    step();
    idle();
    exp_both(2, 32'hFFFFFFFF, 1'b0, "x31_next");

    step();
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      n_total += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
